// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and default sizes.
package mem_copy_engine_pkg;

  localparam int unsigned SDefault = 32;
  localparam int unsigned LDefault = 256;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRd   = 2'd1,
    StWr   = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/mem_copy_engine.sv
// Memory copy engine: bus initiator that copies i_len words from i_src to i_dst over a
// single-port word-addressed memory, one word every two cycles (read, then write).
// Optional running checksum of copied words when MEMCOPY_CHECKSUM_EN is defined.
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int unsigned S  = SDefault,
  parameter int unsigned L  = LDefault,
  localparam int unsigned AW = $clog2(L)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [AW-1:0] i_src,
  input  logic [AW-1:0] i_dst,
  input  logic [AW:0]   i_len,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_a,
  output logic [S-1:0]  o_din,
  input  logic [S-1:0]  i_dout,
  output logic          o_mread,
  output logic          o_mwrite
`ifdef MEMCOPY_CHECKSUM_EN
  ,
  output logic [S-1:0]  o_csum
`endif
);

  state_e        r_state;
  logic [AW-1:0] r_sp;
  logic [AW-1:0] r_dp;
  logic [AW:0]   r_cnt;
  logic [S-1:0]  r_data;
  logic [AW-1:0] r_a;
  logic          r_busy;
  logic          r_done;
  logic          r_mread;
  logic          r_mwrite;
`ifdef MEMCOPY_CHECKSUM_EN
  logic [S-1:0]  r_csum;
`endif

  logic [AW-1:0] w_sp_inc;
  logic [AW-1:0] w_dp_inc;

  // Pointer increments wrap at L-1 so non-power-of-two depths also behave modulo L.
  always_comb begin
    w_sp_inc = (r_sp == AW'(L - 1)) ? '0 : r_sp + AW'(1);
    w_dp_inc = (r_dp == AW'(L - 1)) ? '0 : r_dp + AW'(1);
  end

  // Copy FSM; every output is a register loaded for the state being entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_sp     <= '0;
      r_dp     <= '0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_a      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mread  <= 1'b0;
      r_mwrite <= 1'b0;
`ifdef MEMCOPY_CHECKSUM_EN
      r_csum   <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_sp   <= i_src;
            r_dp   <= i_dst;
            r_cnt  <= i_len;
            r_busy <= 1'b1;
`ifdef MEMCOPY_CHECKSUM_EN
            r_csum <= '0;
`endif
            if (i_len == '0) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state <= StRd;
              r_a     <= i_src;
              r_mread <= 1'b1;
            end
          end
        end
        StRd: begin
          r_data   <= i_dout;
          r_state  <= StWr;
          r_a      <= r_dp;
          r_mread  <= 1'b0;
          r_mwrite <= 1'b1;
        end
        StWr: begin
          r_sp     <= w_sp_inc;
          r_dp     <= w_dp_inc;
          r_cnt    <= r_cnt - (AW + 1)'(1);
          r_mwrite <= 1'b0;
`ifdef MEMCOPY_CHECKSUM_EN
          r_csum   <= r_csum + r_data;
`endif
          if (r_cnt == (AW + 1)'(1)) begin
            r_state <= StDone;
            r_a     <= '0;
            r_done  <= 1'b1;
          end else begin
            r_state <= StRd;
            r_a     <= w_sp_inc;
            r_mread <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_a      = r_a;
  assign o_din    = r_data;
  assign o_mread  = r_mread;
  assign o_mwrite = r_mwrite;
`ifdef MEMCOPY_CHECKSUM_EN
  assign o_csum   = r_csum;
`endif

endmodule
